// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

    function automatic req_vec_t id_to_onehot(input logic [ID_W-1:0] id);
        req_vec_t v;
        v = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pri_enc4.sv
// Four-input priority encoder; the most significant set bit wins.
module pri_enc4
    import arb_pkg::*;
(
    input  logic [3:0] vec,
    output logic [1:0] idx,
    output logic       found
);

    // MSB-first search; an empty vector reports index 0 and found low
    always_comb begin
        idx   = 2'd0;
        found = 1'b1;
        if (vec[3]) begin
            idx = 2'd3;
        end else if (vec[2]) begin
            idx = 2'd2;
        end else if (vec[1]) begin
            idx = 2'd1;
        end else if (vec[0]) begin
            idx = 2'd0;
        end else begin
            found = 1'b0;
        end
    end

endmodule

// File: rtl/req_arbiter.sv
// Four-requester arbiter with hold-time limit and one-shot timeout mask.
// Define REQ_ARBITER_RR_EN for round-robin instead of fixed MSB-first priority.
module req_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       tout
);

    arb_state_t   state_r, state_nxt_s;
    req_vec_t     gnt_r, gnt_nxt_s, mask_r, mask_nxt_s;
    req_vec_t     elig_s, enc_in_s;
    logic [1:0]   gnt_id_r, gnt_id_nxt_s, enc_idx_s, win_id_s;
    logic         gnt_vld_r, tout_r, tout_nxt_s, enc_found_s;
    logic         owner_req_s, hold_done_s;
    logic [7:0]   cnt_r, cnt_nxt_s;

    assign elig_s      = req & ~mask_r;
    assign owner_req_s = |(req & gnt_r);
    assign hold_done_s = (cnt_r == 8'(MAX_HOLD - 1));

`ifdef REQ_ARBITER_RR_EN
    logic [1:0] last_id_r;

    // Rotate so the client after last_id lands on the encoder MSB
    always_comb begin
        enc_in_s = '0;
        for (int j = 0; j < N_REQ; j++) begin
            enc_in_s[j] = elig_s[2'(last_id_r - 2'(j))];
        end
    end

    assign win_id_s = last_id_r - enc_idx_s;

    // Remember the most recent winner for the next rotation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_r <= 2'd0;
        end else if (state_r == ARB_IDLE && enc_found_s) begin
            last_id_r <= win_id_s;
        end else begin
            last_id_r <= last_id_r;
        end
    end
`else
    assign enc_in_s = elig_s;
    assign win_id_s = enc_idx_s;
`endif

    pri_enc4 u_enc (
        .vec   (enc_in_s),
        .idx   (enc_idx_s),
        .found (enc_found_s)
    );

    // State and registered output storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ARB_IDLE;
            gnt_r     <= 4'b0000;
            gnt_id_r  <= 2'd0;
            gnt_vld_r <= 1'b0;
            tout_r    <= 1'b0;
            mask_r    <= 4'b0000;
            cnt_r     <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            gnt_id_r  <= gnt_id_nxt_s;
            gnt_vld_r <= |gnt_nxt_s;
            tout_r    <= tout_nxt_s;
            mask_r    <= mask_nxt_s;
            cnt_r     <= cnt_nxt_s;
        end
    end

    // Next-state decision
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (enc_found_s) begin
                    state_nxt_s = ARB_GRANT;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!owner_req_s || hold_done_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_GRANT;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Next values of grant, counter, mask and timeout pulse
    always_comb begin
        gnt_nxt_s    = gnt_r;
        gnt_id_nxt_s = gnt_id_r;
        tout_nxt_s   = 1'b0;
        mask_nxt_s   = mask_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            ARB_IDLE: begin
                // The mask only ever survives a single arbitration attempt
                mask_nxt_s = 4'b0000;
                cnt_nxt_s  = 8'd0;
                if (enc_found_s) begin
                    gnt_nxt_s    = id_to_onehot(win_id_s);
                    gnt_id_nxt_s = win_id_s;
                end else begin
                    gnt_nxt_s    = 4'b0000;
                    gnt_id_nxt_s = 2'd0;
                end
            end
            ARB_GRANT: begin
                if (!owner_req_s) begin
                    gnt_nxt_s    = 4'b0000;
                    gnt_id_nxt_s = 2'd0;
                end else if (hold_done_s) begin
                    gnt_nxt_s    = 4'b0000;
                    gnt_id_nxt_s = 2'd0;
                    tout_nxt_s   = 1'b1;
                    mask_nxt_s   = gnt_r;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                gnt_nxt_s    = 4'b0000;
                gnt_id_nxt_s = 2'd0;
                mask_nxt_s   = 4'b0000;
                cnt_nxt_s    = 8'd0;
            end
        endcase
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign gnt_vld = gnt_vld_r;
    assign tout    = tout_r;

endmodule

// File: tb/tb_req_arbiter.sv
// Randomized and directed bench for req_arbiter against an ownership-level reference model.
module tb_req_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       tout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the resource, for how many cycles, who is masked
    int m_owner;
    int m_held;
    int m_masked;
    int m_last;
    bit m_tout;

    req_arbiter #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .tout    (tout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] elig, input int last);
        int c;
`ifdef REQ_ARBITER_RR_EN
        for (int k = 1; k <= 4; k++) begin
            c = (last + k) % 4;
            if (elig[c]) return c;
        end
`else
        for (int k = 3; k >= 0; k--) begin
            c = k;
            if (elig[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_held   = 0;
        m_masked = -1;
        m_last   = 0;
        m_tout   = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] elig;
        int w;
        m_tout = 1'b0;
        if (m_owner < 0) begin
            elig = r;
            if (m_masked >= 0) elig[m_masked] = 1'b0;
            m_masked = -1;
            w = pick(elig, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_last  = w;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_held == MH) begin
            m_tout   = 1'b1;
            m_masked = m_owner;
            m_owner  = -1;
        end else begin
            m_held++;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] eg;
        eg = 4'b0000;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check_eq({tag, "_gnt"}, gnt, eg);
        check_eq({tag, "_vld"}, gnt_vld, (m_owner >= 0));
        check_eq({tag, "_tout"}, tout, m_tout);
        if (m_owner >= 0) check_eq({tag, "_id"}, gnt_id, m_owner);
    endtask

    // Check the current outputs, apply a new request vector, advance one cycle
    task automatic cycle(input string tag, input logic [3:0] r);
        check_outputs(tag);
        req = r;
        model_step(r);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        repeat (5) cycle("idle", 4'b0000);

        cycle("t2", 4'b0110);
        check_eq("t2_first_gnt", gnt, 4'b0100);
        check_eq("t2_first_id", gnt_id, 2'd2);
        repeat (2) cycle("t2", 4'b0110);
        cycle("t2", 4'b0010);
        check_eq("t2_gap", gnt, 4'b0000);
        cycle("t2", 4'b0010);
        check_eq("t2_next", gnt, 4'b0010);
        repeat (2) cycle("t2", 4'b0000);

        repeat (5) cycle("t3", 4'b1001);
        check_eq("t3_tout", tout, 1'b1);
        check_eq("t3_tout_gnt", gnt, 4'b0000);
        cycle("t3", 4'b1001);
        check_eq("t3_masked_win", gnt, 4'b0001);
        repeat (2) cycle("t3", 4'b0000);

        repeat (6) cycle("t4", 4'b1000);
        check_eq("t4_masked_idle", gnt, 4'b0000);
        cycle("t4", 4'b1000);
        check_eq("t4_regrant", gnt, 4'b1000);
        repeat (2) cycle("t4", 4'b0000);

        repeat (2) cycle("t5", 4'b0010);
        check_eq("t5_pre_rst", gnt, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_gnt", gnt, 4'b0000);
        check_eq("t5_rst_vld", gnt_vld, 1'b0);
        check_eq("t5_rst_tout", tout, 1'b0);
        check_eq("t5_rst_id", gnt_id, 2'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("t5", 4'b0010);
        check_eq("t5_regrant", gnt, 4'b0010);
        repeat (2) cycle("t5", 4'b0000);

        r = 4'b0000;
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            cycle("rand", r);
        end

        check_outputs("final");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
